pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/CPU_def.sv | 26 ++
 rtl/sat_counter.sv | 21 ++
 rtl/pipe_stage_skid.sv | 141 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/CPU_def.sv
// Shared CPU definitions: default datapath widths and the pipeline-stage
// occupancy state encoding.
package CPU_def;

  localparam int WORD_W        = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int CTRL_BUNDLE_W = 10;
  // read_data_1, read_data_2, pc_plus_4, sign_imm words plus rs, rt, rd addresses
  localparam int DATA_BUNDLE_W = 4 * WORD_W + 3 * REG_ADDR_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_BOTH  = 2'd2
  } stage_state_t;

  function automatic logic [1:0] state_occupancy(input stage_state_t st);
    case (st)
      ST_EMPTY: return 2'd0;
      ST_MAIN:  return 2'd1;
      ST_BOTH:  return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised saturating up-counter with enable and asynchronous
// active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count up on enable, sticking at all-ones.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline register stage carrying control/data bundles, with an optional
// two-entry skid buffer so in_ready can be registered.
module pipe_stage_skid
  import CPU_def::*;
#(
  parameter int CTRL_W = CTRL_BUNDLE_W,
  parameter int DATA_W = DATA_BUNDLE_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  stage_state_t      state_r, state_nx_s;
  logic              out_valid_r, in_ready_r;
  logic [1:0]        occupancy_r;
  logic [CTRL_W-1:0] head_ctrl_r, skid_ctrl_r;
  logic [DATA_W-1:0] head_data_r, skid_data_r;
  logic              accept_s, deq_s;
  logic              load_head_in_s, load_head_skid_s, load_skid_s, drain_head_s;

  // Without the skid entry, readiness must follow the downstream stall directly;
  // in_ready_r still masks the reset window in that mode.
  assign in_ready  = (SKID != 0) ? in_ready_r : (in_ready_r & (out_ready | ~out_valid_r));
  assign accept_s  = in_valid & in_ready & ~flush;
  assign deq_s     = out_valid_r & out_ready;
  assign out_valid = out_valid_r;
  assign out_ctrl  = head_ctrl_r;
  assign out_data  = head_data_r;
  assign occupancy = occupancy_r;

  // Next-state and payload-load decisions; flush overrides everything.
  always_comb begin
    state_nx_s       = state_r;
    load_head_in_s   = 1'b0;
    load_head_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    drain_head_s     = 1'b0;
    if (flush) begin
      state_nx_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nx_s     = ST_MAIN;
            load_head_in_s = 1'b1;
          end else begin
            state_nx_s = ST_EMPTY;
          end
        end
        ST_MAIN: begin
          if (accept_s && deq_s) begin
            load_head_in_s = 1'b1;
          end else if (accept_s) begin
            state_nx_s  = ST_BOTH;
            load_skid_s = 1'b1;
          end else if (deq_s) begin
            state_nx_s   = ST_EMPTY;
            drain_head_s = 1'b1;
          end else begin
            state_nx_s = ST_MAIN;
          end
        end
        ST_BOTH: begin
          if (deq_s) begin
            state_nx_s       = ST_MAIN;
            load_head_skid_s = 1'b1;
          end else begin
            state_nx_s = ST_BOTH;
          end
        end
        default: state_nx_s = ST_EMPTY;
      endcase
    end
  end

  // State and status registers, all derived from the next state.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
      in_ready_r  <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      out_valid_r <= (state_nx_s != ST_EMPTY);
      occupancy_r <= state_occupancy(state_nx_s);
      in_ready_r  <= (state_nx_s != ST_BOTH);
    end
  end

  // Payload registers: load only on accept/promote; control clears when the
  // head drains so a bubble always carries a NOP.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      head_ctrl_r <= '0;
      head_data_r <= '0;
      skid_ctrl_r <= '0;
      skid_data_r <= '0;
    end else if (flush) begin
      head_ctrl_r <= '0;
      head_data_r <= '0;
      skid_ctrl_r <= '0;
      skid_data_r <= '0;
    end else begin
      if (load_head_in_s) begin
        head_ctrl_r <= in_ctrl;
        head_data_r <= in_data;
      end else if (load_head_skid_s) begin
        head_ctrl_r <= skid_ctrl_r;
        head_data_r <= skid_data_r;
      end else if (drain_head_s) begin
        head_ctrl_r <= '0;
      end
      if (load_skid_s) begin
        skid_ctrl_r <= in_ctrl;
        skid_data_r <= in_data;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (flush & (state_r != ST_EMPTY)),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: default skid stage (a_*) and a single-register stage with a
// 2-bit flush counter (b_*).
module tb_pipe_stage_skid;

  logic         clk, clr_n;
  logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [9:0]   a_in_ctrl, a_out_ctrl;
  logic [142:0] a_in_data, a_out_data;
  logic [1:0]   a_occ;
  logic [15:0]  a_fcnt;
  logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [9:0]   b_in_ctrl, b_out_ctrl;
  logic [142:0] b_in_data, b_out_data;
  logic [1:0]   b_occ;
  logic [1:0]   b_fcnt;
  int           pass_cnt = 0;
  int           total_cnt = 0;

  pipe_stage_skid dut_a (
    .clk(clk), .clr_n(clr_n), .flush(a_flush), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
    .out_data(a_out_data), .occupancy(a_occ), .flush_cnt(a_fcnt)
  );

  pipe_stage_skid #(.SKID(0), .CNT_W(2)) dut_b (
    .clk(clk), .clr_n(clr_n), .flush(b_flush), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
    .out_data(b_out_data), .occupancy(b_occ), .flush_cnt(b_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [9:0] c, input logic [142:0] d);
    a_in_valid = v;
    a_in_ctrl  = c;
    a_in_data  = d;
  endtask

  task automatic b_drive(input logic v, input logic [9:0] c, input logic [142:0] d);
    b_in_valid = v;
    b_in_ctrl  = c;
    b_in_data  = d;
  endtask

  initial begin
    clr_n = 1'b0;
    a_flush = 1'b0; a_out_ready = 1'b0; a_drive(1'b0, 10'd0, 143'd0);
    b_flush = 1'b0; b_out_ready = 1'b0; b_drive(1'b0, 10'd0, 143'd0);
    step(); step();
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_in_ready", a_in_ready, 1'b0);
    chk("rst_occ", a_occ, 2'd0);
    chk("rst_fcnt", a_fcnt, 16'd0);
    chk("rst_out_data", a_out_data, 143'd0);
    chk("rst_b_in_ready", b_in_ready, 1'b0);

    clr_n = 1'b1;
    step();
    chk("post_rst_in_ready", a_in_ready, 1'b1);

    // stream A, B, C with no stall
    a_out_ready = 1'b1;
    a_drive(1'b1, 10'h001, 143'h11); step();
    chk("stream_A_data", a_out_data, 143'h11);
    chk("stream_A_ctrl", a_out_ctrl, 10'h001);
    chk("stream_A_valid", a_out_valid, 1'b1);
    a_drive(1'b1, 10'h002, 143'h22); step();
    chk("stream_B_data", a_out_data, 143'h22);
    a_drive(1'b1, 10'h003, 143'h33); step();
    chk("stream_C_data", a_out_data, 143'h33);
    a_drive(1'b0, 10'h000, 143'h0); step();
    chk("drain_valid", a_out_valid, 1'b0);
    chk("drain_ctrl_nop", a_out_ctrl, 10'h000);
    chk("drain_occ", a_occ, 2'd0);

    // skid fill under stall, then release in order
    a_out_ready = 1'b0;
    a_drive(1'b1, 10'h003, 143'hA1); step();
    chk("skid_A_occ", a_occ, 2'd1);
    chk("skid_A_in_ready", a_in_ready, 1'b1);
    a_drive(1'b1, 10'h004, 143'hB2); step();
    chk("skid_full_occ", a_occ, 2'd2);
    chk("skid_full_in_ready", a_in_ready, 1'b0);
    chk("skid_full_head", a_out_data, 143'hA1);
    a_drive(1'b1, 10'h005, 143'hC3); step();
    chk("skid_hold_occ", a_occ, 2'd2);
    chk("skid_hold_head", a_out_data, 143'hA1);
    chk("skid_hold_ctrl", a_out_ctrl, 10'h003);
    a_drive(1'b0, 10'h000, 143'h0); a_out_ready = 1'b1; step();
    chk("skid_promote_data", a_out_data, 143'hB2);
    chk("skid_promote_ctrl", a_out_ctrl, 10'h004);
    chk("skid_promote_occ", a_occ, 2'd1);
    chk("skid_promote_in_ready", a_in_ready, 1'b1);
    step();
    chk("skid_empty_valid", a_out_valid, 1'b0);

    // flush with both entries held and an input offered
    a_out_ready = 1'b0;
    a_drive(1'b1, 10'h006, 143'hD4); step();
    a_drive(1'b1, 10'h007, 143'hE5); step();
    chk("pre_flush_occ", a_occ, 2'd2);
    a_drive(1'b1, 10'h008, 143'hF6); a_flush = 1'b1; step();
    chk("flush_valid", a_out_valid, 1'b0);
    chk("flush_ctrl", a_out_ctrl, 10'h000);
    chk("flush_data", a_out_data, 143'd0);
    chk("flush_occ", a_occ, 2'd0);
    chk("flush_cnt1", a_fcnt, 16'd1);
    chk("flush_in_ready", a_in_ready, 1'b1);
    a_flush = 1'b0; a_drive(1'b0, 10'h000, 143'h0); step();
    chk("flush_no_ghost", a_out_valid, 1'b0);

    // flush in MAIN discards the offered entry; flush while empty does not count
    a_drive(1'b1, 10'h009, 143'h55); step();
    a_drive(1'b1, 10'h00A, 143'h66); a_flush = 1'b1; step();
    chk("flush_main_occ", a_occ, 2'd0);
    chk("flush_cnt2", a_fcnt, 16'd2);
    a_drive(1'b0, 10'h000, 143'h0); step();
    chk("flush_empty_cnt", a_fcnt, 16'd2);
    a_flush = 1'b0; step();

    // asynchronous reset mid-cycle with one entry held
    a_drive(1'b1, 10'h00B, 143'h77); step();
    a_drive(1'b0, 10'h000, 143'h0);
    chk("pre_async_occ", a_occ, 2'd1);
    #2 clr_n = 1'b0;
    #1;
    chk("async_valid", a_out_valid, 1'b0);
    chk("async_ctrl", a_out_ctrl, 10'h000);
    chk("async_occ", a_occ, 2'd0);
    chk("async_fcnt", a_fcnt, 16'd0);
    chk("async_in_ready", a_in_ready, 1'b0);
    step();
    clr_n = 1'b1;
    step();
    chk("async_recover_in_ready", a_in_ready, 1'b1);

    // single-register stage: combinational backpressure and full throughput
    b_drive(1'b1, 10'h010, 143'h1); step();
    chk("b_hold_valid", b_out_valid, 1'b1);
    chk("b_stall_in_ready", b_in_ready, 1'b0);
    b_drive(1'b1, 10'h011, 143'h2); step();
    chk("b_stall_data", b_out_data, 143'h1);
    chk("b_stall_occ", b_occ, 2'd1);
    b_out_ready = 1'b1; #1;
    chk("b_comb_in_ready", b_in_ready, 1'b1);
    step();
    chk("b_tput_2", b_out_data, 143'h2);
    b_drive(1'b1, 10'h012, 143'h3); step();
    chk("b_tput_3", b_out_data, 143'h3);
    b_drive(1'b1, 10'h013, 143'h4); step();
    chk("b_tput_4", b_out_data, 143'h4);
    chk("b_tput_ctrl", b_out_ctrl, 10'h013);
    b_drive(1'b0, 10'h000, 143'h0); step();
    chk("b_drain_valid", b_out_valid, 1'b0);
    chk("b_drain_occ", b_occ, 2'd0);

    // saturating flush counter: empty flush ignored, 5 effective flushes -> 3
    b_out_ready = 1'b0;
    b_flush = 1'b1; step(); b_flush = 1'b0;
    chk("b_empty_flush_cnt", b_fcnt, 2'd0);
    for (int i = 0; i < 5; i++) begin
      b_drive(1'b1, 10'h020, 143'h9); step();
      b_drive(1'b0, 10'h000, 143'h0); b_flush = 1'b1; step();
      b_flush = 1'b0;
    end
    chk("b_sat_cnt", b_fcnt, 2'd3);
    chk("b_sat_occ", b_occ, 2'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
